// File: rtl/instr_encoder_if.sv
// Field-set input bus and encoded-word output bus of the instruction encoder.
// The master drives fields and out_ready; the slave (encoder) returns words and status.
interface instr_encoder_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  in_valid;
    logic                  in_ready;
    logic [6:0]            in_opcode;
    logic [4:0]            in_rd;
    logic [4:0]            in_rs1;
    logic [4:0]            in_rs2;
    logic [2:0]            in_funct3;
    logic [6:0]            in_funct7;
    logic [31:0]           in_imm;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_word;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic                  err_imm;
    logic                  err_op;

    modport master (
        output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
        output out_ready,
        input  in_ready, out_valid, out_word, out_addr, err_imm, err_op
    );

    modport slave (
        input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
        input  out_ready,
        output in_ready, out_valid, out_word, out_addr, err_imm, err_op
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs RV32I fields into instruction words, streamed with sequential word addresses.
// Define INSTR_ENCODER_IMM_CHECK_EN to build the immediate range/alignment checker (err_imm).
module instr_encoder #(
    parameter int                    ADDR_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    instr_encoder_if.slave  bus
);
    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_J,
        FMT_U,
        FMT_BAD
    } fmt_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    fmt_e                  fmt;
    logic [31:0]           imm;
    logic [31:0]           enc_word;
    logic                  in_ready;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] cnt_base;

    logic                  out_valid_q, out_valid_d;
    logic [31:0]           out_word_q,  out_word_d;
    logic [ADDR_WIDTH-1:0] out_addr_q,  out_addr_d;
    logic [ADDR_WIDTH-1:0] addr_cnt_q,  addr_cnt_d;
    logic                  err_op_q,    err_op_d;

    assign imm = bus.in_imm;

    always_comb begin
        fmt = FMT_BAD;
        case (bus.in_opcode)
            7'b0000011, 7'b0010011, 7'b1100111: fmt = FMT_I;
            7'b0100011:                         fmt = FMT_S;
            7'b1100011:                         fmt = FMT_B;
            7'b1101111:                         fmt = FMT_J;
            7'b0110111, 7'b0010111:             fmt = FMT_U;
            7'b0110011:                         fmt = FMT_R;
            default:                            fmt = FMT_BAD;
        endcase
    end

    // Bits the format cannot represent are simply not selected here.
    always_comb begin
        enc_word = NOP_WORD;
        case (fmt)
            FMT_R: enc_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                               bus.in_rd, bus.in_opcode};
            FMT_I: enc_word = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
            FMT_S: enc_word = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                               imm[4:0], bus.in_opcode};
            FMT_B: enc_word = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                               imm[4:1], imm[11], bus.in_opcode};
            FMT_J: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
            FMT_U: enc_word = {imm[31:12], bus.in_rd, bus.in_opcode};
            default: enc_word = NOP_WORD;
        endcase
    end

    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

    // clear wins over the running count, so a simultaneous accept lands on BASE_ADDR.
    always_comb begin
        cnt_base    = clear ? BASE_ADDR : addr_cnt_q;
        addr_cnt_d  = accept ? cnt_base + ADDR_WIDTH'(1) : cnt_base;
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        out_addr_d  = out_addr_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_word_d  = enc_word;
            out_addr_d  = cnt_base;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        err_op_d = (clear ? 1'b0 : err_op_q) | (accept && (fmt == FMT_BAD));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_word_q  <= 32'h0;
            out_addr_q  <= BASE_ADDR;
            addr_cnt_q  <= BASE_ADDR;
            err_op_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            out_addr_q  <= out_addr_d;
            addr_cnt_q  <= addr_cnt_d;
            err_op_q    <= err_op_d;
        end
    end

`ifdef INSTR_ENCODER_IMM_CHECK_EN
    logic imm_bad;
    logic err_imm_q, err_imm_d;

    // An immediate is representable when all bits above the format's top bit copy its sign.
    always_comb begin
        imm_bad = 1'b0;
        case (fmt)
            FMT_I, FMT_S: imm_bad = (imm[31:11] != {21{imm[11]}});
            FMT_B:        imm_bad = (imm[31:12] != {20{imm[12]}}) || imm[0];
            FMT_J:        imm_bad = (imm[31:20] != {12{imm[20]}}) || imm[0];
            FMT_U:        imm_bad = (imm[11:0] != 12'h0);
            default:      imm_bad = 1'b0;
        endcase
    end

    always_comb begin
        err_imm_d = (clear ? 1'b0 : err_imm_q) | (accept && imm_bad);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_imm_q <= 1'b0;
        end else begin
            err_imm_q <= err_imm_d;
        end
    end

    assign bus.err_imm = err_imm_q;
`else
    assign bus.err_imm = 1'b0;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_word  = out_word_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.err_op    = err_op_q;
endmodule
